// File: rtl/harvard_pkg.sv
// Shared definitions for the Harvard machine: opcode constants, sequencer
// state encodings and instruction word field positions.
package harvard_pkg;

   localparam int OPC_MSB  = 21;
   localparam int OPC_LSB  = 17;
   localparam int MODE_BIT = 16;
   localparam int OPR_MSB  = 15;
   localparam int INSTR_WIDTH = OPC_MSB + 1;

   localparam logic [4:0] OP_JMP  = 5'b01000;
   localparam logic [4:0] OP_JZ   = 5'b01001;
   localparam logic [4:0] OP_HALT = 5'b11111;

   typedef enum logic [2:0] {
      ST_FETCH   = 3'd0,
      ST_LATCH   = 3'd1,
      ST_OPERAND = 3'd2,
      ST_ISSUE   = 3'd3,
      ST_EXECUTE = 3'd4,
      ST_HALT    = 3'd5
   } seqState_t;

endpackage

// File: rtl/instruction_sequencer.sv
// Fetch/decode/execute controller: owns the PC, resolves direct operands and
// hands one instruction at a time to the decoder. Jumps and HALT resolve here.
//
// state   | meaning
// FETCH   | PC on ROM address, ROM word arrives next cycle
// LATCH   | capture ROM word into IR, pick operand path
// OPERAND | direct operand read outstanding, wait for ack
// ISSUE   | one-cycle decode strobe; jumps/HALT resolve here
// EXECUTE | wait for datapath done, then PC+1
// HALT    | frozen until reset
module instruction_sequencer
   import harvard_pkg::*;
#(
   parameter int         PC_WIDTH   = 8,
   parameter int         DATA_WIDTH = 16,
   parameter logic [4:0] OP_JMP     = harvard_pkg::OP_JMP,
   parameter logic [4:0] OP_JZ      = harvard_pkg::OP_JZ,
   parameter logic [4:0] OP_HALT    = harvard_pkg::OP_HALT
) (
   input  logic                   ClockInput,
   input  logic                   ResetInput,
   output logic [PC_WIDTH-1:0]    InstrAddressOutput,
   input  logic [INSTR_WIDTH-1:0] InstrDataInput,
   output logic [DATA_WIDTH-1:0]  DataAddressOutput,
   output logic                   DataReadReqOutput,
   input  logic                   DataAckInput,
   input  logic [DATA_WIDTH-1:0]  DataReadInput,
   output logic [4:0]             OpecodeOutput,
   output logic [DATA_WIDTH-1:0]  OperandOutput,
   output logic                   AddressingModeOutput,
   output logic                   DecodeValidOutput,
   input  logic                   ExecDoneInput,
   input  logic                   ZeroFlagInput,
   output logic                   HaltOutput,
   output logic [2:0]             StateOutput
);

   seqState_t               state;
   logic [PC_WIDTH-1:0]     pc;
   logic [INSTR_WIDTH-1:0]  ir;

   logic [4:0]              romOpc;
   logic                    romMode;
   logic [OPR_MSB:0]        romOpr;
   logic [4:0]              irOpc;
   logic [PC_WIDTH-1:0]     irTarget;
   logic                    romIsFlow;

   assign romOpc    = InstrDataInput[OPC_MSB:OPC_LSB];
   assign romMode   = InstrDataInput[MODE_BIT];
   assign romOpr    = InstrDataInput[OPR_MSB:0];
   assign irOpc     = ir[OPC_MSB:OPC_LSB];
   assign irTarget  = ir[PC_WIDTH-1:0];
   assign romIsFlow = (romOpc == OP_JMP) || (romOpc == OP_JZ) || (romOpc == OP_HALT);

   assign InstrAddressOutput   = pc;
   assign OpecodeOutput        = ir[OPC_MSB:OPC_LSB];
   assign AddressingModeOutput = ir[MODE_BIT];
   assign StateOutput          = state;

   always_ff @(posedge ClockInput) begin
      if (ResetInput) begin
         state             <= ST_FETCH;
         pc                <= '0;
         ir                <= '0;
         OperandOutput     <= '0;
         DataAddressOutput <= '0;
         DataReadReqOutput <= 1'b0;
         DecodeValidOutput <= 1'b0;
         HaltOutput        <= 1'b0;
      end else begin
         DecodeValidOutput <= 1'b0;
         case (state)
            ST_FETCH: state <= ST_LATCH;
            ST_LATCH: begin
               ir            <= InstrDataInput;
               OperandOutput <= romOpr;
               // Flow-control opcodes never fetch from data memory, whatever their mode bit.
               if (romMode && !romIsFlow) begin
                  DataAddressOutput <= romOpr;
                  DataReadReqOutput <= 1'b1;
                  state             <= ST_OPERAND;
               end else begin
                  DecodeValidOutput <= 1'b1;
                  state             <= ST_ISSUE;
               end
            end
            ST_OPERAND: begin
               if (DataAckInput) begin
                  OperandOutput     <= DataReadInput;
                  DataReadReqOutput <= 1'b0;
                  DecodeValidOutput <= 1'b1;
                  state             <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (irOpc == OP_HALT) begin
                  HaltOutput <= 1'b1;
                  state      <= ST_HALT;
               end else if (irOpc == OP_JMP) begin
                  pc    <= irTarget;
                  state <= ST_FETCH;
               end else if (irOpc == OP_JZ) begin
                  pc    <= ZeroFlagInput ? irTarget : pc + 1'b1;
                  state <= ST_FETCH;
               end else begin
                  state <= ST_EXECUTE;
               end
            end
            ST_EXECUTE: begin
               if (ExecDoneInput) begin
                  pc    <= pc + 1'b1;
                  state <= ST_FETCH;
               end
            end
            ST_HALT: state <= ST_HALT;
            default: state <= ST_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: registered ROM model, hand-driven
// data-memory ack and exec-done, cycle-exact expectations.
module tb_instruction_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  instrAddr;
   logic [21:0] instrData;
   logic [15:0] dataAddr;
   logic        dataReq;
   logic        dataAck;
   logic [15:0] dataRead;
   logic [4:0]  opcode;
   logic [15:0] operand;
   logic        mode;
   logic        decodeValid;
   logic        execDone;
   logic        zeroFlag;
   logic        halt;
   logic [2:0]  state;

   logic [21:0] rom [256];

   int checks = 0;
   int errors = 0;

   instruction_sequencer dut (
      .ClockInput          (clk),
      .ResetInput          (rst),
      .InstrAddressOutput  (instrAddr),
      .InstrDataInput      (instrData),
      .DataAddressOutput   (dataAddr),
      .DataReadReqOutput   (dataReq),
      .DataAckInput        (dataAck),
      .DataReadInput       (dataRead),
      .OpecodeOutput       (opcode),
      .OperandOutput       (operand),
      .AddressingModeOutput(mode),
      .DecodeValidOutput   (decodeValid),
      .ExecDoneInput       (execDone),
      .ZeroFlagInput       (zeroFlag),
      .HaltOutput          (halt),
      .StateOutput         (state)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk) instrData <= rom[instrAddr];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = '0;
      rom[8'h00] = {5'b00011, 1'b0, 16'h0005};
      rom[8'h01] = {5'b00011, 1'b1, 16'h0020};
      rom[8'h02] = {5'b01000, 1'b0, 16'h0340};
      rom[8'h40] = {5'b01001, 1'b0, 16'h0080};
      rom[8'h41] = {5'b01001, 1'b0, 16'h00FF};
      rom[8'hFF] = {5'b00011, 1'b0, 16'h1234};
      rst = 1'b1; dataAck = 1'b0; dataRead = '0; execDone = 1'b0; zeroFlag = 1'b0;
      tick(); tick();

      // reset state
      checkVal("rst_state", state, 0);
      checkVal("rst_pc", instrAddr, 0);
      checkVal("rst_opc", opcode, 0);
      checkVal("rst_opr", operand, 0);
      checkVal("rst_dv", decodeValid, 0);
      checkVal("rst_req", dataReq, 0);
      checkVal("rst_halt", halt, 0);
      rst = 1'b0;

      // 1: immediate instruction
      tick(); checkVal("t1_latch", state, 1);
      tick();
      checkVal("t1_issue", state, 3);
      checkVal("t1_dv", decodeValid, 1);
      checkVal("t1_opc", opcode, 5'b00011);
      checkVal("t1_opr", operand, 16'h0005);
      checkVal("t1_mode", mode, 0);
      tick();
      checkVal("t1_exec", state, 4);
      checkVal("t1_dv_drop", decodeValid, 0);
      checkVal("t1_opr_hold", operand, 16'h0005);
      tick();
      checkVal("t1_exec_wait", state, 4);
      checkVal("t1_pc_wait", instrAddr, 0);
      execDone = 1'b1;
      tick();
      execDone = 1'b0;
      checkVal("t1_fetch", state, 0);
      checkVal("t1_pc", instrAddr, 1);

      // 2: direct operand, ack in the fourth OPERAND cycle
      tick(); tick();
      checkVal("t2_operand", state, 2);
      checkVal("t2_addr", dataAddr, 16'h0020);
      checkVal("t2_dv_none", decodeValid, 0);
      for (int c = 2; c <= 4; c++) begin
         checkVal("t2_req_hold", dataReq, 1);
         tick();
      end
      checkVal("t2_req_last", dataReq, 1);
      checkVal("t2_addr_hold", dataAddr, 16'h0020);
      dataAck = 1'b1; dataRead = 16'hBEEF;
      tick();
      dataAck = 1'b0; dataRead = 16'h0000;
      checkVal("t2_issue", state, 3);
      checkVal("t2_req_drop", dataReq, 0);
      checkVal("t2_dv", decodeValid, 1);
      checkVal("t2_opr", operand, 16'hBEEF);
      checkVal("t2_mode", mode, 1);
      execDone = 1'b1;
      tick();
      checkVal("t2_exec", state, 4);
      tick();
      execDone = 1'b0;
      checkVal("t2_pc", instrAddr, 2);

      // 3: JMP with truncated target, then JZ not-taken and taken
      tick(); tick();
      checkVal("t3_jmp_issue", state, 3);
      tick();
      checkVal("t3_jmp_state", state, 0);
      checkVal("t3_jmp_pc", instrAddr, 8'h40);
      tick(); tick(); tick();
      checkVal("t3_jz0_state", state, 0);
      checkVal("t3_jz0_pc", instrAddr, 8'h41);
      zeroFlag = 1'b1;
      tick(); tick(); tick();
      zeroFlag = 1'b0;
      checkVal("t3_jz1_pc", instrAddr, 8'hFF);

      // 4: PC wrap; stray ack outside OPERAND must be ignored
      dataAck = 1'b1; dataRead = 16'hDEAD;
      tick();
      checkVal("t4_req_latch", dataReq, 0);
      tick();
      checkVal("t4_issue", state, 3);
      checkVal("t4_req_issue", dataReq, 0);
      checkVal("t4_opr", operand, 16'h1234);
      tick();
      checkVal("t4_exec", state, 4);
      execDone = 1'b1;
      tick();
      execDone = 1'b0; dataAck = 1'b0;
      checkVal("t4_wrap_pc", instrAddr, 8'h00);
      checkVal("t4_fetch", state, 0);

      // 5: HALT with mode bit set never requests data; only reset exits
      rom[8'h00] = {5'b11111, 1'b1, 16'h0000};
      tick(); tick();
      checkVal("t5_issue", state, 3);
      checkVal("t5_req", dataReq, 0);
      tick();
      checkVal("t5_halt", halt, 1);
      checkVal("t5_state", state, 5);
      for (int c = 0; c < 8; c++) begin
         execDone = c[0];
         dataAck  = c[1];
         tick();
         checkVal("t5_halt_hold", halt, 1);
         checkVal("t5_state_hold", state, 5);
         checkVal("t5_req_hold", dataReq, 0);
         checkVal("t5_pc_hold", instrAddr, 0);
      end
      execDone = 1'b0; dataAck = 1'b0;
      rom[8'h00] = {5'b00011, 1'b1, 16'h0010};
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkVal("t5_rst_state", state, 0);
      checkVal("t5_rst_halt", halt, 0);
      checkVal("t5_rst_pc", instrAddr, 0);

      // 6: reset while waiting for a data ack
      tick(); tick();
      checkVal("t6_operand", state, 2);
      checkVal("t6_req", dataReq, 1);
      checkVal("t6_addr", dataAddr, 16'h0010);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkVal("t6_req_drop", dataReq, 0);
      checkVal("t6_state", state, 0);
      checkVal("t6_pc", instrAddr, 0);
      checkVal("t6_opr", operand, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
